i2c_config_sequencer: RTL and testbench

Sequences the I2C transceiver to write a table of codec/TV-decoder register settings after power-up or on request. Each table entry is one 3-byte write: device address, register address, data. The sequence for each entry is START, 3 bytes with ACK check, STOP. The block sits between a small config ROM and the transceiver, and drives the transceiver's handshake pins directly.

---
 rtl/i2c_config_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: walks a config ROM of {dev_addr, reg_addr, reg_data}
// entries and drives an I2C transceiver through START, three bytes with ACK
// checks, and STOP per entry, re-sending an entry after a NACK up to
// MAX_RETRIES times.
// Optional macro I2C_CFG_WATCHDOG_EN adds a per-state watchdog that aborts a
// stuck handshake after TIMEOUT_CYCLES clocks and flags an error.
module i2c_config_sequencer #(
  parameter int NUM_ENTRIES    = 16,
  parameter int ADDR_W         = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              auto_init,
  input  logic [23:0]       rom_data,
  output logic [ADDR_W-1:0] rom_address,
  input  logic              transfer_complete,
  input  logic              ack,
  output logic              send_start_bit,
  output logic              send_stop_bit,
  output logic              transfer_data,
  output logic [7:0]        data_out,
  output logic              read_byte,
  output logic [2:0]        num_bits_to_transfer,
  output logic              clear_ack,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    IDLE, START, WAIT_REL, BYTE, CHECK, STOP, NEXT, DONE, ERROR
  } state_t;

  state_t      state;
  state_t      ret_state;
  logic [1:0]  byte_idx;
  logic [7:0]  retry_cnt;
  logic        retry_flag;
  logic [7:0]  byte_sel;
  logic        wd_fire;

  // Write-only sequencer: every transfer is a full 8-bit write.
  assign read_byte            = 1'b0;
  assign num_bits_to_transfer = 3'h7;

  // Pick the byte of the current entry addressed by byte_idx.
  always_comb begin
    case (byte_idx)
      2'd0:    byte_sel = rom_data[23:16];
      2'd1:    byte_sel = rom_data[15:8];
      default: byte_sel = rom_data[7:0];
    endcase
  end

`ifdef I2C_CFG_WATCHDOG_EN
  state_t      state_q;
  logic [15:0] wd_cnt;

  // Count cycles spent in the current state (the entry cycle counts as 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wd_cnt  <= 16'd0;
    end else begin
      state_q <= state;
      if (state != state_q) begin
        wd_cnt <= 16'd1;
      end else if (wd_cnt != 16'hFFFF) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end

  assign wd_fire = (state == state_q) &&
                   (({16'd0, wd_cnt} + 32'd1) >= 32'(TIMEOUT_CYCLES)) &&
                   ((state == START) || (state == BYTE) ||
                    (state == STOP)  || (state == WAIT_REL));
`else
  assign wd_fire = 1'b0;
`endif

  // Main sequencer: commands are held until transfer_complete, then dropped,
  // and the next command waits in WAIT_REL for transfer_complete to fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ret_state      <= IDLE;
      rom_address    <= '0;
      byte_idx       <= 2'd0;
      retry_cnt      <= 8'd0;
      retry_flag     <= 1'b0;
      send_start_bit <= 1'b0;
      send_stop_bit  <= 1'b0;
      transfer_data  <= 1'b0;
      data_out       <= 8'd0;
      clear_ack      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      clear_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (auto_init) begin
            clear_ack  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b1;
            byte_idx   <= 2'd0;
            retry_cnt  <= 8'd0;
            retry_flag <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (send_start_bit && transfer_complete) begin
            send_start_bit <= 1'b0;
            ret_state      <= BYTE;
            state          <= WAIT_REL;
          end else begin
            send_start_bit <= 1'b1;
          end
        end
        WAIT_REL: begin
          if (!transfer_complete) begin
            state <= ret_state;
          end
        end
        BYTE: begin
          data_out <= byte_sel;
          if (transfer_data && transfer_complete) begin
            transfer_data <= 1'b0;
            ret_state     <= CHECK;
            state         <= WAIT_REL;
          end else begin
            transfer_data <= 1'b1;
          end
        end
        CHECK: begin
          // A NACK abandons the rest of the entry; STOP then NEXT decides on a retry.
          if (ack) begin
            retry_flag <= 1'b1;
            state      <= STOP;
          end else if (byte_idx < 2'd2) begin
            byte_idx <= byte_idx + 2'd1;
            state    <= BYTE;
          end else begin
            state <= STOP;
          end
        end
        STOP: begin
          if (send_stop_bit && transfer_complete) begin
            send_stop_bit <= 1'b0;
            ret_state     <= NEXT;
            state         <= WAIT_REL;
          end else begin
            send_stop_bit <= 1'b1;
          end
        end
        NEXT: begin
          if (retry_flag && (retry_cnt < 8'(MAX_RETRIES))) begin
            retry_cnt  <= retry_cnt + 8'd1;
            retry_flag <= 1'b0;
            byte_idx   <= 2'd0;
            clear_ack  <= 1'b1;
            state      <= START;
          end else if (retry_flag) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ERROR;
          end else if (rom_address == ADDR_W'(NUM_ENTRIES - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            rom_address <= rom_address + 1'b1;
            retry_cnt   <= 8'd0;
            byte_idx    <= 2'd0;
            clear_ack   <= 1'b1;
            state       <= START;
          end
        end
        DONE, ERROR: begin
          if (!auto_init) begin
            rom_address <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A stalled handshake overrides whatever the state decided this cycle.
      if (wd_fire) begin
        send_start_bit <= 1'b0;
        send_stop_bit  <= 1'b0;
        transfer_data  <= 1'b0;
        error          <= 1'b1;
        busy           <= 1'b0;
        state          <= ERROR;
      end
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Testbench for i2c_config_sequencer: a transceiver responder with random
// completion latency and release hold, a NACK plan indexed by attempt, and a
// reference model that expands ROM + NACK plan into the expected bus events.
module tb_i2c_config_sequencer;
  localparam int N  = 2;
  localparam int MR = 3;
`ifdef I2C_CFG_WATCHDOG_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif
  localparam int EV_S = 256;
  localparam int EV_P = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, auto_init, transfer_complete, ack;
  logic [23:0] rom_data;
  logic [7:0]  rom_address;
  logic        send_start_bit, send_stop_bit, transfer_data, read_byte;
  logic [7:0]  data_out;
  logic [2:0]  num_bits_to_transfer;
  logic        clear_ack, busy, done, error;

  logic [23:0] rom [N];
  int          nack_plan [16];
  int          obs [$];
  int          exp_q [$];
  int          hold_lo, hold_hi, att, nbytes, viol;
  bit          resp_en;
  int          checks = 0;
  int          passed = 0;

  assign rom_data = (int'(rom_address) < N) ? rom[rom_address[0]] : 24'h0;

  i2c_config_sequencer #(
    .NUM_ENTRIES(N), .ADDR_W(8), .MAX_RETRIES(MR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .auto_init(auto_init), .rom_data(rom_data),
    .rom_address(rom_address), .transfer_complete(transfer_complete), .ack(ack),
    .send_start_bit(send_start_bit), .send_stop_bit(send_stop_bit),
    .transfer_data(transfer_data), .data_out(data_out), .read_byte(read_byte),
    .num_bits_to_transfer(num_bits_to_transfer), .clear_ack(clear_ack),
    .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
  endtask

  // Transceiver model plus handshake/one-hot monitor, acting 1 time unit after each edge.
  initial begin : responder
    int  phase, cnt, bi;
    bit  ps, pd, pp;
    phase = 0; cnt = 0; bi = 0; ps = 0; pd = 0; pp = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        phase = 0; transfer_complete = 1'b0; ack = 1'b0; ps = 0; pd = 0; pp = 0;
      end else begin
        if ((int'(send_start_bit) + int'(transfer_data) + int'(send_stop_bit)) > 1) viol++;
        if (transfer_complete && ((send_start_bit && !ps) || (transfer_data && !pd) ||
                                  (send_stop_bit && !pp))) viol++;
        ps = send_start_bit; pd = transfer_data; pp = send_stop_bit;
        if (clear_ack) ack = 1'b0;
        if (resp_en) begin
          case (phase)
            0: if (ps || pd || pp) begin cnt = $urandom_range(3, 0); phase = 1; end
            1: begin
              if (!(ps || pd || pp)) phase = 0;
              else if (cnt == 0) begin
                transfer_complete = 1'b1;
                phase = 2;
                if (ps) begin obs.push_back(EV_S); att++; bi = 0; end
                else if (pp) obs.push_back(EV_P);
                else begin
                  obs.push_back(int'(data_out));
                  if (att >= 1 && att <= 16 && nack_plan[att-1] == bi) ack = 1'b1;
                  bi++; nbytes++;
                end
              end else cnt--;
            end
            2: if (!(ps || pd || pp)) begin
              cnt = $urandom_range(hold_hi, hold_lo);
              if (cnt == 0) begin transfer_complete = 1'b0; phase = 0; end
              else phase = 3;
            end
            default: begin
              cnt--;
              if (cnt <= 0) begin transfer_complete = 1'b0; phase = 0; end
            end
          endcase
        end
      end
    end
  end

  // Expand ROM and NACK plan into the event list a correct sequencer produces.
  task automatic model_pass(output bit exp_done, output bit exp_err);
    int k;
    k = 0; exp_q.delete(); exp_err = 0;
    for (int e = 0; e < N && !exp_err; e++) begin
      for (int a = 0; a <= MR; a++) begin
        int nb;
        nb = nack_plan[k]; k++;
        exp_q.push_back(EV_S);
        for (int b = 0; b < 3; b++) begin
          exp_q.push_back(int'(rom[e][23-8*b -: 8]));
          if (nb == b) break;
        end
        exp_q.push_back(EV_P);
        if (nb < 0) break;
        if (a == MR) exp_err = 1;
      end
    end
    exp_done = !exp_err;
  endtask

  function automatic int count_ev(input int code);
    int c;
    c = 0;
    foreach (obs[i]) if (obs[i] == code) c++;
    return c;
  endfunction

  task automatic run_pass(input string tag, input int hlo, input int hhi, input bit short_init);
    bit ed, ee;
    int cyc;
    hold_lo = hlo; hold_hi = hhi; obs.delete(); att = 0; nbytes = 0; viol = 0;
    model_pass(ed, ee);
    @(negedge clk); auto_init = 1'b1;
    @(negedge clk);
    check({tag, "_busy_on"}, busy, 1);
    check({tag, "_done_clr"}, done, 0);
    if (short_init) auto_init = 1'b0;
    cyc = 0;
    while (!(done || error) && cyc < 4000) begin @(negedge clk); cyc++; end
    check({tag, "_finished"}, done || error, 1);
    check({tag, "_ev_len"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), obs[i], exp_q[i]);
    check({tag, "_done"}, done, ed);
    check({tag, "_error"}, error, ee);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_protocol"}, viol, 0);
    auto_init = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_addr_rst"}, rom_address, 0);
    check({tag, "_done_sticky"}, done, ed);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; auto_init = 1'b0; transfer_complete = 1'b0; ack = 1'b0;
    resp_en = 1; hold_lo = 0; hold_hi = 0; att = 0; nbytes = 0; viol = 0;
    foreach (nack_plan[i]) nack_plan[i] = -1;
    rom[0] = 24'h341E00; rom[1] = 24'h341201;
    repeat (3) @(negedge clk);
    check("rst_start", send_start_bit, 0);
    check("rst_data", transfer_data, 0);
    check("rst_stop", send_stop_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_clear_ack", clear_ack, 0);
    check("rst_read_byte", read_byte, 0);
    check("rst_nbits", num_bits_to_transfer, 7);
    check("rst_addr", rom_address, 0);
    check("rst_data_out", data_out, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_init", busy, 0);

    run_pass("basic", 0, 2, 0);
    check("basic_starts", count_ev(EV_S), 2);
    check("basic_stops", count_ev(EV_P), 2);
    run_pass("hold5", 5, 5, 0);

    nack_plan[0] = 1;
    run_pass("retry1", 0, 3, 0);
    check("retry1_starts", count_ev(EV_S), 3);

    foreach (nack_plan[i]) nack_plan[i] = $urandom_range(2, 0);
    run_pass("nack_all", 0, 3, 0);
    check("nack_all_starts", count_ev(EV_S), MR + 1);
    check("nack_all_stops", count_ev(EV_P), MR + 1);

    for (int t = 0; t < 6; t++) begin
      rom[0] = 24'($urandom()); rom[1] = 24'($urandom());
      foreach (nack_plan[i]) nack_plan[i] = ($urandom_range(9, 0) < 3) ? $urandom_range(2, 0) : -1;
      run_pass($sformatf("rand%0d", t), 0, 5, t[0]);
    end

    // Reset while byte 2 of entry 1 is being sent.
    foreach (nack_plan[i]) nack_plan[i] = -1;
    hold_lo = 0; hold_hi = 2; obs.delete(); att = 0; nbytes = 0;
    @(negedge clk); auto_init = 1'b1;
    cyc = 0;
    while (!(transfer_data && nbytes == 5 && !transfer_complete) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    check("midrst_reached", transfer_data && nbytes == 5, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_data", transfer_data, 0);
    check("midrst_start", send_start_bit, 0);
    check("midrst_stop", send_stop_bit, 0);
    check("midrst_addr", rom_address, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    auto_init = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("midrst_idle", busy, 0);
    run_pass("after_rst", 0, 2, 0);

`ifdef I2C_CFG_WATCHDOG_EN
    resp_en = 0;
    @(negedge clk); auto_init = 1'b1;
    repeat (100) @(negedge clk);
    check("wd_before_err", error, 0);
    check("wd_start_held", send_start_bit, 1);
    @(negedge clk);
    check("wd_err", error, 1);
    check("wd_start_drop", send_start_bit, 0);
    check("wd_busy", busy, 0);
    auto_init = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
